// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory_controller channel between the CPU fetch port
//            (read-only) and the load/store port (read/write with byte mask).
//            Requests are serialised onto a single rw_flag/busy/done
//            handshake. Read data goes back to the granted port, and fetches
//            cancelled by a pipeline flush are dropped.
// Ports    : clk, rst_n                   clock, async active-low reset
//            if_req_i/if_addr_i           fetch request (level) and address
//            if_flush_i                   cancel outstanding fetch (pulse)
//            if_rdata_o/if_done_o         fetch data + one-cycle completion
//            ls_req_i/ls_we_i/ls_addr_i   load/store request, direction, addr
//            ls_wdata_i/ls_mask_i         store data and byte mask
//            ls_rdata_o/ls_done_o         load data + one-cycle completion
//            mem_rw_flag_o                01 read, 10 write, 00 idle
//            mem_addr_o/mem_w_data_o      request fields to the controller
//            mem_w_mask_o                 byte mask to the controller
//            mem_r_data_i/mem_busy_i      controller read data / back-pressure
//            mem_done_i                   controller completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [3:0]        ls_mask_i,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_done_o,
    output logic [1:0]        mem_rw_flag_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_w_data_o,
    output logic [3:0]        mem_w_mask_o,
    input  logic [DATA_W-1:0] mem_r_data_i,
    input  logic              mem_busy_i,
    input  logic              mem_done_i
);

    localparam int                    c_STREAK_W   = $clog2(STREAK_MAX + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(STREAK_MAX);
    localparam logic [1:0]            c_RW_IDLE    = 2'b00;
    localparam logic [1:0]            c_RW_READ    = 2'b01;
    localparam logic [1:0]            c_RW_WRITE   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_grant_ls;   // 1: load/store owns the channel
    logic                  r_is_write;   // granted transaction is a store
    logic                  r_discard;    // fetch flushed after acceptance
    logic [c_STREAK_W-1:0] r_streak;     // load/store grants while fetch waits

    logic w_if_elig;
    logic w_ls_elig;
    logic w_pick_ls;
    logic w_grant;
    logic w_accept;
    logic w_withdraw;
    logic w_complete;

    // A port whose done pulse is out this cycle is still seeing its own
    // completion and may not have dropped req yet, so it sits this cycle out.
    always_comb begin
        w_if_elig    = if_req_i & ~if_done_o;
        w_ls_elig    = ls_req_i & ~ls_done_o;
        w_pick_ls    = w_ls_elig & ~(w_if_elig & (r_streak == c_STREAK_MAX));
        w_grant      = 1'b0;
        w_accept     = 1'b0;
        w_withdraw   = 1'b0;
        w_complete   = 1'b0;
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_if_elig | w_ls_elig) begin
                    w_grant      = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Acceptance wins over a same-cycle flush: the controller has
                // taken the request, so it must be drained and discarded.
                if (!mem_busy_i) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WAIT;
                end else if (!r_grant_ls && if_flush_i) begin
                    w_withdraw   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_done_i) begin
                    w_complete   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_ls    <= 1'b0;
            r_is_write    <= 1'b0;
            r_discard     <= 1'b0;
            r_streak      <= '0;
            mem_rw_flag_o <= c_RW_IDLE;
            mem_addr_o    <= '0;
            mem_w_data_o  <= '0;
            mem_w_mask_o  <= '0;
            if_rdata_o    <= '0;
            if_done_o     <= 1'b0;
            ls_rdata_o    <= '0;
            ls_done_o     <= 1'b0;
        end else begin
            if_done_o <= 1'b0;
            ls_done_o <= 1'b0;

            if (w_grant) begin
                r_grant_ls <= w_pick_ls;
                if (w_pick_ls) begin
                    r_is_write    <= ls_we_i;
                    mem_rw_flag_o <= ls_we_i ? c_RW_WRITE : c_RW_READ;
                    mem_addr_o    <= ls_addr_i;
                    mem_w_data_o  <= ls_wdata_i;
                    mem_w_mask_o  <= ls_mask_i;
                    if (w_if_elig) begin
                        if (r_streak != c_STREAK_MAX) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end else begin
                        r_streak <= '0;
                    end
                end else begin
                    r_is_write    <= 1'b0;
                    mem_rw_flag_o <= c_RW_READ;
                    mem_addr_o    <= if_addr_i;
                    mem_w_data_o  <= '0;
                    mem_w_mask_o  <= '0;
                    r_streak      <= '0;
                end
            end

            if (w_accept || w_withdraw) begin
                mem_rw_flag_o <= c_RW_IDLE;
            end

            if (w_accept) begin
                r_discard <= ~r_grant_ls & if_flush_i;
            end

            if (r_state == S_WAIT && !r_grant_ls && if_flush_i) begin
                r_discard <= 1'b1;
            end

            if (w_complete) begin
                r_discard <= 1'b0;
                if (r_grant_ls) begin
                    ls_done_o <= 1'b1;
                    // Store completions leave the last load data in place.
                    if (!r_is_write) begin
                        ls_rdata_o <= mem_r_data_i;
                    end
                end else if (!r_discard && !if_flush_i) begin
                    if_done_o  <= 1'b1;
                    if_rdata_o <= mem_r_data_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter. The bench
//            acts as both CPU ports and the memory controller; every expected
//            completion is queued when the request is driven and popped by a
//            monitor when a done pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STREAK_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_done_o;
    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic [3:0]        ls_mask_i;
    logic [DATA_W-1:0] ls_rdata_o;
    logic              ls_done_o;
    logic [1:0]        mem_rw_flag_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_w_data_o;
    logic [3:0]        mem_w_mask_o;
    logic [DATA_W-1:0] mem_r_data_i;
    logic              mem_busy_i;
    logic              mem_done_i;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STREAK_MAX (STREAK_MAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_flush_i    (if_flush_i),
        .if_rdata_o    (if_rdata_o),
        .if_done_o     (if_done_o),
        .ls_req_i      (ls_req_i),
        .ls_we_i       (ls_we_i),
        .ls_addr_i     (ls_addr_i),
        .ls_wdata_i    (ls_wdata_i),
        .ls_mask_i     (ls_mask_i),
        .ls_rdata_o    (ls_rdata_o),
        .ls_done_o     (ls_done_o),
        .mem_rw_flag_o (mem_rw_flag_o),
        .mem_addr_o    (mem_addr_o),
        .mem_w_data_o  (mem_w_data_o),
        .mem_w_mask_o  (mem_w_mask_o),
        .mem_r_data_i  (mem_r_data_i),
        .mem_busy_i    (mem_busy_i),
        .mem_done_i    (mem_done_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_ls;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_ls_rdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are sampled and
    // inputs for the new cycle are driven at this point.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (mem_rw_flag_o == 2'b00 && n < 20) begin
            cyc();
            n++;
        end
        check({tag, "_issue_timeout"}, 64'(mem_rw_flag_o != 2'b00), 64'd1);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest queued entry.
    always begin
        @(posedge clk);
        #2;
        if (if_done_o === 1'b1 || ls_done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {if_done_o, ls_done_o}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_port", {if_done_o, ls_done_o}, mon_e.is_ls ? 64'd1 : 64'd2);
                check("done_rdata", mon_e.is_ls ? ls_rdata_o : if_rdata_o, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        granted_ls;
        logic [31:0] d;
        logic [5:0]  exp_order;

        rst_n = 1'b0;  if_req_i = 1'b0;  if_addr_i = '0;  if_flush_i = 1'b0;
        ls_req_i = 1'b0;  ls_we_i = 1'b0;  ls_addr_i = '0;  ls_wdata_i = '0;
        ls_mask_i = '0;  mem_r_data_i = '0;  mem_busy_i = 1'b0;  mem_done_i = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_flag",  mem_rw_flag_o, 64'd0);
        check("rst_addr",  mem_addr_o, 64'd0);
        check("rst_done",  {if_done_o, ls_done_o}, 64'd0);
        check("rst_rdata", {if_rdata_o, ls_rdata_o}, 64'd0);
        rst_n = 1'b1;
        cyc();

        // ---------------- single fetch ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        sb_q.push_back('{is_ls: 1'b0, data: 32'hDEADBEEF});
        m_if_rdata = 32'hDEADBEEF;
        cyc();
        check("t1_flag_read", mem_rw_flag_o, 64'd1);
        check("t1_addr", mem_addr_o, 64'h100);
        check("t1_mask", mem_w_mask_o, 64'd0);
        cyc();
        check("t1_flag_one_cycle", mem_rw_flag_o, 64'd0);
        cyc();
        cyc();
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'hDEADBEEF;
        cyc();
        mem_done_i   = 1'b0;
        mem_r_data_i = '0;
        check("t1_if_done", if_done_o, 64'd1);
        if_req_i = 1'b0;
        cyc();
        check("t1_done_one_cycle", if_done_o, 64'd0);
        n = 0;
        repeat (4) begin
            if (mem_rw_flag_o != 2'b00) n++;
            cyc();
        end
        check("t1_no_reissue", 64'(n), 64'd0);

        // ---------------- streak fairness ----------------
        // Fetch is raised together with each load grant and withdrawn (with a
        // flush) before the load completes, so it is pending at every load
        // grant. After four such grants the fetch must win.
        exp_order = 6'b101111;
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 32'h3000;
        if_addr_i = 32'h4000;
        for (int g = 0; g < 6; g++) begin
            if (g < 5) if_req_i = 1'b1;
            wait_issue("t3");
            granted_ls = (mem_addr_o == 32'h3000);
            check($sformatf("t3_grant%0d_is_ls", g), 64'(granted_ls), 64'(exp_order[g]));
            d = 32'hA000_0000 + 32'(g);
            sb_q.push_back('{is_ls: granted_ls, data: d});
            if (granted_ls) m_ls_rdata = d;
            else            m_if_rdata = d;
            if (granted_ls && g < 4) begin
                if_req_i   = 1'b0;
                if_flush_i = 1'b1;
            end
            cyc();
            if_flush_i   = 1'b0;
            mem_done_i   = 1'b1;
            mem_r_data_i = d;
            cyc();
            mem_done_i   = 1'b0;
            if (!granted_ls) if_req_i = 1'b0;
            if (g == 5)      ls_req_i = 1'b0;
            cyc();
        end

        // ---------------- store with back-pressure ----------------
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b1;
        ls_addr_i  = 32'h2000;
        ls_wdata_i = 32'h11223344;
        ls_mask_i  = 4'b0011;
        mem_busy_i = 1'b1;
        sb_q.push_back('{is_ls: 1'b1, data: m_ls_rdata});
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (mem_rw_flag_o == 2'b10 && mem_addr_o == 32'h2000 &&
                mem_w_data_o == 32'h11223344 && mem_w_mask_o == 4'b0011) n++;
            if (i == 1) begin
                ls_addr_i  = 32'h9999;
                ls_wdata_i = 32'hFFFF_FFFF;
            end
            if (i == 4) mem_busy_i = 1'b0;
        end
        check("t2_flag_held_cycles", 64'(n), 64'd5);
        cyc();
        check("t2_flag_drop", mem_rw_flag_o, 64'd0);
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'hBADBAD00;
        cyc();
        mem_done_i   = 1'b0;
        check("t2_ls_done", ls_done_o, 64'd1);
        check("t2_ls_rdata_kept", ls_rdata_o, m_ls_rdata);
        ls_req_i = 1'b0;
        ls_we_i  = 1'b0;
        cyc();

        // ---------------- flush in ISSUE while busy ----------------
        if_req_i   = 1'b1;
        if_addr_i  = 32'h400;
        mem_busy_i = 1'b1;
        cyc();
        check("t4_issue", mem_rw_flag_o, 64'd1);
        if_flush_i = 1'b1;
        if_req_i   = 1'b0;
        cyc();
        if_flush_i = 1'b0;
        check("t4_withdrawn", mem_rw_flag_o, 64'd0);
        mem_busy_i = 1'b0;
        n = 0;
        repeat (3) begin
            cyc();
            if (mem_rw_flag_o != 2'b00 || if_done_o) n++;
        end
        check("t4_idle_quiet", 64'(n), 64'd0);

        // ---------------- flush in WAIT, load pending ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h500;
        cyc();
        check("t5_if_addr", mem_addr_o, 64'h500);
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 32'h600;
        cyc();
        if_flush_i = 1'b1;
        if_req_i   = 1'b0;
        cyc();
        if_flush_i   = 1'b0;
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'h55;
        cyc();
        mem_done_i = 1'b0;
        check("t5_no_if_done", if_done_o, 64'd0);
        check("t5_if_rdata_kept", if_rdata_o, m_if_rdata);
        cyc();
        check("t5_ls_flag", mem_rw_flag_o, 64'd1);
        check("t5_ls_addr", mem_addr_o, 64'h600);
        sb_q.push_back('{is_ls: 1'b1, data: 32'h66});
        m_ls_rdata = 32'h66;
        cyc();
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'h66;
        cyc();
        mem_done_i = 1'b0;
        check("t5_ls_done", ls_done_o, 64'd1);
        ls_req_i = 1'b0;
        cyc();

        // ---------------- reset during WAIT ----------------
        ls_req_i  = 1'b1;
        ls_addr_i = 32'h700;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_flag", mem_rw_flag_o, 64'd0);
        check("t6_rst_addr", mem_addr_o, 64'd0);
        check("t6_rst_rdata", {if_rdata_o, ls_rdata_o}, 64'd0);
        m_ls_rdata = '0;
        m_if_rdata = '0;
        ls_req_i   = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'h77;
        cyc();
        mem_done_i = 1'b0;
        check("t6_no_ls_done", ls_done_o, 64'd0);
        check("t6_ls_rdata", ls_rdata_o, 64'd0);
        repeat (3) cyc();

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one `memory_controller` channel between the CPU's instruction-fetch port (read-only) and load/store port (read/write with byte mask). Sits between `cpu` and `memory_controller`. Serializes the two requesters onto the single `mem_rw_flag`/`mem_busy`/`mem_done` handshake, returns read data to the winner, and discards fetches cancelled by a pipeline flush.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STREAK_MAX`, 4, consecutive data grants allowed while a fetch is pending

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req_i`  in  1  fetch request; level, held until `if_done_o` or `if_flush_i`
- `if_addr_i`  in  ADDR_W  fetch address; stable while `if_req_i`
- `if_flush_i`  in  1  cancel outstanding fetch (pulse)
- `if_rdata_o`  out  DATA_W  fetched word, valid with `if_done_o`
- `if_done_o`  out  1  one-cycle completion pulse
- `ls_req_i`  in  1  load/store request; level, held until `ls_done_o`
- `ls_we_i`  in  1  1 = write, 0 = read
- `ls_addr_i`  in  ADDR_W  address
- `ls_wdata_i`  in  DATA_W  write data
- `ls_mask_i`  in  4  byte write mask
- `ls_rdata_o`  out  DATA_W  load data, valid with `ls_done_o`
- `ls_done_o`  out  1  one-cycle completion pulse
- `mem_rw_flag_o`  out  2  01 read, 10 write, 00 idle
- `mem_addr_o`  out  ADDR_W  address to controller
- `mem_w_data_o`  out  DATA_W  write data to controller
- `mem_w_mask_o`  out  4  byte mask to controller
- `mem_r_data_i`  in  DATA_W  read data from controller
- `mem_busy_i`  in  1  controller cannot accept a request
- `mem_done_i`  in  1  one-cycle completion from controller

## Operation
- States: IDLE, ISSUE, WAIT. Reset → IDLE. Every output 0, `streak` 0, `grant` 0, `discard` 0.
- IDLE: the eligible request set is the requesters whose req is high, minus the port whose done is high this cycle. If the set is empty, stay in IDLE.
  - Otherwise pick the winner and latch `grant`, addr, rw, wdata and mask into output registers. Go to ISSUE.
  - Fetch reads use rw = 01 and mask 0.
- Priority: load/store wins over fetch. Exception: fetch wins if both are pending and `streak == STREAK_MAX`.
- `streak` updates:
  - increments on each load/store grant made while fetch is pending, saturating at STREAK_MAX;
  - clears on any fetch grant;
  - clears on a load/store grant made while fetch is idle.
- ISSUE: `mem_rw_flag_o` is nonzero. The request is accepted on the cycle `mem_busy_i == 0`. On acceptance go to WAIT and drive `mem_rw_flag_o` to 00 on the next cycle.
- WAIT: on `mem_done_i`, register `mem_r_data_i` into the granted port's rdata and pulse its done, unless `discard` is set. Go to IDLE and clear `discard`.
- rdata outputs hold their value between completions.
- Writes also return a done pulse. `ls_rdata_o` is then undefined; it keeps its previous value.
- Flush:
  - `if_flush_i` in IDLE: no effect. The fetch port drops its req itself.
  - `if_flush_i` in ISSUE with fetch granted, request not yet accepted: withdraw the request (`mem_rw_flag_o` → 00 next cycle) and go to IDLE. No `if_done_o`.
  - `if_flush_i` in ISSUE on the acceptance cycle, or in WAIT: set `discard`. The transaction completes downstream, and `if_done_o` is suppressed.
- Flush never affects a load/store grant.
- Request fields are captured at grant. Requester changes after grant are ignored.

## Timing
- Best case with req at cycle 0:
  - grant at edge 1, ISSUE;
  - accepted in cycle 1 if not busy;
  - WAIT from edge 2;
  - controller done in cycle k ≥ 2;
  - requester done pulse in cycle k+1 (registered); back in IDLE at edge k+1.
- A held req from the same port can re-grant in cycle k+2. The other port can be granted in cycle k+1.
- `mem_rw_flag_o` stays asserted across busy cycles. Address, data and mask are stable for the whole of ISSUE.
- At most one transaction is outstanding. `mem_done_i` outside WAIT is ignored.
- `if_done_o` and `ls_done_o` are never high in the same cycle.
- Reset assertion mid-transaction forces IDLE with all outputs 0 immediately. A later stray `mem_done_i` is ignored.

## Test plan
- Single fetch, addr 0x100, busy 0, done 3 cycles after accept with data 0xDEADBEEF:
  - `mem_rw_flag_o` = 01 for exactly one cycle;
  - `if_rdata_o` = 0xDEADBEEF with a one-cycle `if_done_o`;
  - no second issue.
- Store addr 0x2000, data 0x11223344, mask 0011, with busy high for 4 cycles:
  - flag 10 held 5 cycles with stable fields;
  - one `ls_done_o`.
- Fetch and load/store continuously requesting, STREAK_MAX = 4: grant order LS, LS, LS, LS, IF, repeating.
- Flush in ISSUE while busy high: flag drops to 00 next cycle, no `if_done_o`, state returns to IDLE.
- Flush in WAIT: controller done with 0x55 produces no `if_done_o`, and `if_rdata_o` is unchanged. A pending load/store is granted next.
- `rst_n` low during WAIT: all outputs 0 asynchronously. A following `mem_done_i` produces no done pulse.
